// File: rtl/audio_capture_pkg.sv
// Shared widths, sample/address types and the capture-action decode for audio_capture.
// Both the interface and the datapath import this package.
package audio_pkg;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned DEPTH       = 256;
  localparam int unsigned SYNC_STAGES = 2;

  typedef logic [DATA_W-1:0] sample_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // One action per clock, resolved in priority order.
  typedef enum logic [1:0] {
    CAP_IDLE    = 2'd0,
    CAP_WRITE   = 2'd1,
    CAP_OVERRUN = 2'd2,
    CAP_REARM   = 2'd3
  } cap_op_e;

  // A rearm always wins, so a strobe arriving together with the ack is dropped.
  function automatic cap_op_e decode_op(input logic flag, input logic pulse,
                                        input logic full);
    cap_op_e op;
    op = CAP_IDLE;
    if (flag) begin
      op = CAP_REARM;
    end else if (pulse && full) begin
      op = CAP_OVERRUN;
    end else if (pulse) begin
      op = CAP_WRITE;
    end
    return op;
  endfunction

endpackage

// File: rtl/audio_capture_if.sv
// Arduino/processor-side signal bundle for audio_capture.
// master drives strobe/data/address/ack; slave returns the registered status and read data.
interface audio_capture_if;
  import audio_pkg::*;

  logic    read_arduino_in;
  sample_t data;
  addr_t   PC_out;
  logic    flag;
  sample_t sample_out;
  addr_t   wr_ptr;
  logic    buf_full;
  logic    overrun;

  modport master (
    output read_arduino_in, data, PC_out, flag,
    input  sample_out, wr_ptr, buf_full, overrun
  );

  modport slave (
    input  read_arduino_in, data, PC_out, flag,
    output sample_out, wr_ptr, buf_full, overrun
  );

endinterface

// File: rtl/audio_capture_sync_edge_detect.sv
// Multi-stage synchroniser for an asynchronous line followed by a rising-edge detector.
// Produces one clock-wide pulse per rise, however long the line stays high.
module sync_edge_detect #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_pulse_c
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Shift chain; r_prev holds the last synchronised level for edge compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_pulse_c = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/audio_capture.sv
// Captures strobed Arduino samples into a DEPTH-entry buffer and serves processor reads by address.
// Capture stops when the buffer fills, until the processor acknowledges with flag.
module audio_capture
  import audio_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  audio_capture_if.slave  bus
);

  logic    w_pulse;
  cap_op_e w_op;
  logic    w_wr_en;
  addr_t   w_wr_ptr_nxt;
  logic    w_buf_full_nxt;
  logic    w_overrun_nxt;

  addr_t   r_wr_ptr;
  logic    r_buf_full;
  logic    r_overrun;
  sample_t r_sample;
  sample_t r_mem [DEPTH];

  sync_edge_detect #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_async   (bus.read_arduino_in),
    .o_pulse_c (w_pulse)
  );

  // Capture control: next pointer/status and the RAM write enable.
  always_comb begin
    w_wr_en        = 1'b0;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_buf_full_nxt = r_buf_full;
    w_overrun_nxt  = r_overrun;
    w_op           = decode_op(bus.flag, w_pulse, r_buf_full);
    case (w_op)
      CAP_REARM: begin
        w_wr_ptr_nxt   = '0;
        w_buf_full_nxt = 1'b0;
        w_overrun_nxt  = 1'b0;
      end
      CAP_OVERRUN: begin
        w_overrun_nxt = 1'b1;
      end
      CAP_WRITE: begin
        w_wr_en      = 1'b1;
        w_wr_ptr_nxt = r_wr_ptr + ADDR_W'(1);
        if (r_wr_ptr == ADDR_W'(DEPTH - 1)) begin
          w_buf_full_nxt = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_buf_full <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_buf_full <= w_buf_full_nxt;
      r_overrun  <= w_overrun_nxt;
    end
  end

  // Buffer write port; contents deliberately survive reset and rearm.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= bus.data;
    end
  end

  // Read port sees the pre-write word on an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample <= '0;
    end else begin
      r_sample <= r_mem[bus.PC_out];
    end
  end

  assign bus.sample_out = r_sample;
  assign bus.wr_ptr     = r_wr_ptr;
  assign bus.buf_full   = r_buf_full;
  assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_audio_capture.sv
// Self-checking bench for audio_capture: randomized strobes against a sample-count buffer model.
module tb_audio_capture;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  audio_capture_if bus ();

  audio_capture dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: number of samples accepted since rearm plus every word ever stored.
  logic [7:0] m_mem   [256];
  bit         m_valid [256];
  int         m_count;
  bit         m_ovr;

  function automatic void model_strobe(input logic [7:0] d);
    if (m_count == 256) begin
      m_ovr = 1'b1;
    end else begin
      m_mem[m_count]   = d;
      m_valid[m_count] = 1'b1;
      m_count++;
    end
  endfunction

  function automatic void model_rearm();
    m_count = 0;
    m_ovr   = 1'b0;
  endfunction

  function automatic logic [7:0] exp_ptr();
    return 8'(m_count % 256);
  endfunction

  // One strobe: rise with data, hold high `hold` clocks, then low `low` clocks.
  task automatic send(input logic [7:0] d, input int hold, input int low);
    @(negedge clk);
    bus.data            = d;
    bus.read_arduino_in = 1'b1;
    model_strobe(d);
    repeat (hold) @(negedge clk);
    bus.read_arduino_in = 1'b0;
    repeat (low) @(negedge clk);
  endtask

  task automatic do_read(input logic [7:0] a, output logic [7:0] v);
    @(negedge clk);
    bus.PC_out = a;
    @(posedge clk);
    #1 v = bus.sample_out;
  endtask

  task automatic test_reset();
    rst_n               = 1'b0;
    bus.read_arduino_in = 1'b0;
    bus.data            = '0;
    bus.PC_out          = '0;
    bus.flag            = 1'b0;
    model_rearm();
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.wr_ptr, bus.sample_out, bus.buf_full, bus.overrun} !== 18'h0) begin
      errors++;
      $display("FAIL reset_outputs got ptr=%0d smp=%h full=%b ovr=%b exp all 0",
               bus.wr_ptr, bus.sample_out, bus.buf_full, bus.overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    logic [7:0] v;
    @(negedge clk);
    bus.data            = 8'h01;
    bus.read_arduino_in = 1'b1;
    model_strobe(8'h01);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.wr_ptr !== 8'd0) begin
      errors++;
      $display("FAIL single_early got wr_ptr=%0d exp 0", bus.wr_ptr);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.wr_ptr !== 8'd1) begin
      errors++;
      $display("FAIL single_latency got wr_ptr=%0d exp 1", bus.wr_ptr);
    end
    repeat (2) @(negedge clk);
    bus.read_arduino_in = 1'b0;
    repeat (3) @(negedge clk);
    do_read(8'd0, v);
    checks++;
    if (v !== 8'h01) begin
      errors++;
      $display("FAIL single_read got %h exp 01", v);
    end
  endtask

  task automatic test_sequence();
    logic [7:0] v;
    logic [7:0] seq [5];
    seq = '{8'h01, 8'h01, 8'h02, 8'h01, 8'h01};
    model_rearm();
    @(negedge clk);
    bus.flag = 1'b1;
    @(negedge clk);
    bus.flag = 1'b0;
    for (int i = 0; i < 5; i++) send(seq[i], 4, 4);
    checks++;
    if (bus.wr_ptr !== 8'd5) begin
      errors++;
      $display("FAIL seq_wr_ptr got %0d exp 5", bus.wr_ptr);
    end
    do_read(8'd2, v);
    checks++;
    if (v !== 8'h02) begin
      errors++;
      $display("FAIL seq_read2 got %h exp 02", v);
    end
  endtask

  task automatic test_long_strobe();
    send(8'hA5, 20, 4);
    checks++;
    if (bus.wr_ptr !== exp_ptr()) begin
      errors++;
      $display("FAIL long_strobe got wr_ptr=%0d exp %0d", bus.wr_ptr, exp_ptr());
    end
  endtask

  task automatic test_random();
    logic [7:0] v;
    logic [7:0] a;
    int         hold;
    for (int i = 0; i < 30; i++) begin
      hold = int'($urandom_range(1, 5));
      send(8'($urandom), hold, (hold < 3) ? 3 : 2);
      checks++;
      if (bus.wr_ptr !== exp_ptr()) begin
        errors++;
        $display("FAIL rand_wr_ptr[%0d] got %0d exp %0d", i, bus.wr_ptr, exp_ptr());
      end
    end
    for (int i = 0; i < 12; i++) begin
      a = 8'($urandom_range(0, m_count - 1));
      do_read(a, v);
      checks++;
      if (v !== m_mem[a]) begin
        errors++;
        $display("FAIL rand_read[%0d] addr %0d got %h exp %h", i, a, v, m_mem[a]);
      end
    end
  endtask

  task automatic test_full_overrun();
    logic [7:0] v;
    while (m_count < 256) send(8'($urandom), int'($urandom_range(1, 2)), 3);
    checks++;
    if ({bus.buf_full, bus.wr_ptr, bus.overrun} !== {1'b1, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL full_state got full=%b ptr=%0d ovr=%b exp 1/0/0",
               bus.buf_full, bus.wr_ptr, bus.overrun);
    end
    send(~m_mem[255], 2, 4);
    checks++;
    if ({bus.buf_full, bus.wr_ptr, bus.overrun} !== {1'b1, 8'd0, m_ovr}) begin
      errors++;
      $display("FAIL overrun_state got full=%b ptr=%0d ovr=%b exp 1/0/%b",
               bus.buf_full, bus.wr_ptr, bus.overrun, m_ovr);
    end
    do_read(8'd255, v);
    checks++;
    if (v !== m_mem[255]) begin
      errors++;
      $display("FAIL full_last_word got %h exp %h", v, m_mem[255]);
    end
    do_read(8'd0, v);
    checks++;
    if (v !== m_mem[0]) begin
      errors++;
      $display("FAIL full_no_overwrite0 got %h exp %h", v, m_mem[0]);
    end
    @(negedge clk);
    bus.flag = 1'b1;
    model_rearm();
    @(negedge clk);
    bus.flag = 1'b0;
    checks++;
    if ({bus.buf_full, bus.wr_ptr, bus.overrun} !== 10'h0) begin
      errors++;
      $display("FAIL rearm got full=%b ptr=%0d ovr=%b exp 0/0/0",
               bus.buf_full, bus.wr_ptr, bus.overrun);
    end
  endtask

  task automatic test_read_before_write();
    logic [7:0] old_w;
    logic [7:0] new_w;
    old_w = m_mem[0];
    new_w = ~old_w;
    @(negedge clk);
    bus.PC_out          = 8'd0;
    bus.data            = new_w;
    bus.read_arduino_in = 1'b1;
    model_strobe(new_w);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.sample_out !== old_w) begin
      errors++;
      $display("FAIL rbw_old got %h exp %h", bus.sample_out, old_w);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.sample_out !== new_w) begin
      errors++;
      $display("FAIL rbw_new got %h exp %h", bus.sample_out, new_w);
    end
    @(negedge clk);
    bus.read_arduino_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    logic [7:0] v;
    logic [7:0] keep1;
    keep1 = m_mem[1];
    @(negedge clk);
    bus.data            = ~keep1;
    bus.read_arduino_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.flag = 1'b1;
    model_rearm();
    @(negedge clk);
    bus.flag            = 1'b0;
    bus.read_arduino_in = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({bus.wr_ptr, bus.buf_full} !== 9'h0) begin
      errors++;
      $display("FAIL simul_drop got ptr=%0d full=%b exp 0/0", bus.wr_ptr, bus.buf_full);
    end
    do_read(8'd1, v);
    checks++;
    if (v !== keep1) begin
      errors++;
      $display("FAIL simul_mem1 got %h exp %h", v, keep1);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) send(8'h80 | 8'($urandom), 2, 3);
    @(negedge clk);
    bus.PC_out = 8'd0;
    @(negedge clk);
    bus.read_arduino_in = 1'b1;
    bus.data            = 8'h5A;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.wr_ptr, bus.sample_out, bus.buf_full, bus.overrun} !== 18'h0) begin
      errors++;
      $display("FAIL async_reset got ptr=%0d smp=%h full=%b ovr=%b exp all 0",
               bus.wr_ptr, bus.sample_out, bus.buf_full, bus.overrun);
    end
    @(negedge clk);
    bus.read_arduino_in = 1'b0;
    model_rearm();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.wr_ptr !== 8'd0) begin
      errors++;
      $display("FAIL post_reset_ptr got %0d exp 0", bus.wr_ptr);
    end
    send(8'h3C, 3, 3);
    checks++;
    if (bus.wr_ptr !== exp_ptr()) begin
      errors++;
      $display("FAIL post_reset_capture got %0d exp %0d", bus.wr_ptr, exp_ptr());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_sequence();
    test_long_strobe();
    test_random();
    test_full_overrun();
    test_read_before_write();
    test_simultaneous();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
